// File: rtl/gpu_pkg.sv
// Shared types and sizing for the per-core thread scheduler.
// Thread, retire and scheduler state encodings live here.
package gpu_pkg;

  localparam int NUM_THREADS = 16;
  localparam int TID_W       = 4;
  localparam int DATA_W      = 18;

  typedef enum logic [1:0] {
    TS_READY,
    TS_IN_FLIGHT,
    TS_MEM_WAIT,
    TS_EXITED
  } thread_state_t;

  typedef enum logic [1:0] {
    RK_NORMAL = 2'd0,
    RK_MEM    = 2'd1,
    RK_EXIT   = 2'd2
  } retire_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_NEXT,
    S_DONE
  } sched_state_t;

  function automatic thread_state_t retire_next(
    input logic [1:0] kind
  );
    thread_state_t s;
    s = TS_EXITED;
    unique case (1'b1)
      kind == RK_NORMAL: s = TS_READY;
      kind == RK_MEM:    s = TS_MEM_WAIT;
      default:           s = TS_EXITED;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Issue handshake plus retire / memory-response
// event lines between scheduler and pipeline.
interface thread_scheduler_if;
  import gpu_pkg::*;

  logic             issue_valid;
  logic             issue_ready;
  logic [TID_W-1:0] issue_thread;
  logic             retire_valid;
  logic [TID_W-1:0] retire_thread;
  logic [1:0]       retire_kind;
  logic             mem_resp_valid;
  logic [TID_W-1:0] mem_resp_thread;

  modport master (
    output issue_valid,
    output issue_thread,
    input  issue_ready,
    input  retire_valid,
    input  retire_thread,
    input  retire_kind,
    input  mem_resp_valid,
    input  mem_resp_thread
  );

  modport slave (
    input  issue_valid,
    input  issue_thread,
    output issue_ready,
    output retire_valid,
    output retire_thread,
    output retire_kind,
    output mem_resp_valid,
    output mem_resp_thread
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request
// at or after ptr, cyclically (N a power of two).
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] idx;

  // Scan farthest-first so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + W'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Launches a kernel block by block over 16 threads,
// offering one READY thread per cycle round-robin.
module thread_scheduler
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] num_blocks,
  output logic [DATA_W-1:0] block_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  thread_scheduler_if.master sif
);

  sched_state_t     state, state_n;
  thread_state_t    ts   [NUM_THREADS];
  thread_state_t    ts_n [NUM_THREADS];
  logic [TID_W-1:0] rr_ptr, rr_ptr_n;
  logic [DATA_W-1:0] nb, nb_n, blk_n;
  logic             err_n;

  logic [NUM_THREADS-1:0] rdy_mask, ext_mask;
  logic             gnt_v;
  logic [TID_W-1:0] gnt_i;
  logic             offer, fire;
  logic             last_blk, launch;

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      rdy_mask[i] = ts[i] == TS_READY;
      ext_mask[i] = ts[i] == TS_EXITED;
    end
  end

  rr_arbiter #(
    .N (NUM_THREADS),
    .W (TID_W)
  ) u_arb (
    .req         (rdy_mask),
    .ptr         (rr_ptr),
    .grant_valid (gnt_v),
    .grant_idx   (gnt_i)
  );

  assign offer    = state == S_RUN && gnt_v;
  assign fire     = offer && sif.issue_ready;
  assign last_blk = block_idx == nb - DATA_W'(1);
  assign launch   = state == S_IDLE && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_n = (num_blocks == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (&ext_mask) state_n = S_NEXT;
      S_NEXT:
        state_n = last_blk ? S_DONE : S_RUN;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    sif.issue_valid  = offer;
    sif.issue_thread = offer ? gnt_i : '0;
    busy             = state != S_IDLE;
    done             = state == S_DONE;
  end

  // Events read the registered state, so a retire
  // aimed at the thread being issued is an error.
  always_comb begin
    ts_n     = ts;
    rr_ptr_n = rr_ptr;
    blk_n    = block_idx;
    nb_n     = nb;
    err_n    = err;
    if (fire) begin
      ts_n[gnt_i] = TS_IN_FLIGHT;
      rr_ptr_n    = gnt_i + TID_W'(1);
    end
    if (sif.retire_valid) begin
      if (ts[sif.retire_thread] == TS_IN_FLIGHT &&
          sif.retire_kind != 2'b11)
        ts_n[sif.retire_thread] =
          retire_next(sif.retire_kind);
      else
        err_n = 1'b1;
    end
    if (sif.mem_resp_valid) begin
      if (ts[sif.mem_resp_thread] == TS_MEM_WAIT)
        ts_n[sif.mem_resp_thread] = TS_READY;
      else
        err_n = 1'b1;
    end
    if (launch) begin
      nb_n  = num_blocks;
      err_n = 1'b0;
      blk_n = '0;
      if (num_blocks != '0) begin
        for (int i = 0; i < NUM_THREADS; i++)
          ts_n[i] = TS_READY;
        rr_ptr_n = '0;
      end
    end
    if (state == S_NEXT && !last_blk) begin
      blk_n = block_idx + DATA_W'(1);
      for (int i = 0; i < NUM_THREADS; i++)
        ts_n[i] = TS_READY;
      rr_ptr_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_THREADS; i++)
        ts[i] <= TS_EXITED;
      rr_ptr    <= '0;
      block_idx <= '0;
      nb        <= '0;
      err       <= 1'b0;
    end else begin
      ts        <= ts_n;
      rr_ptr    <= rr_ptr_n;
      block_idx <= blk_n;
      nb        <= nb_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Randomised bench for thread_scheduler with an
// in-bench behavioural model and directed scenarios.
module tb_thread_scheduler;
  import gpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] num_blocks = '0;
  logic [DATA_W-1:0] block_idx;
  logic              busy, done, err;

  thread_scheduler_if sif();

  thread_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_blocks (num_blocks),
    .block_idx  (block_idx),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sif        (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam int RDY = 0, INF = 1, MW = 2, EX = 3;
  localparam int P_IDLE = 0, P_RUN = 1;
  localparam int P_NEXT = 2, P_DONE = 3;

  int th [16];
  int ptr, blk, nblk, ph;
  bit merr;
  bit last_fire;
  int last_thread;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    foreach (th[i]) th[i] = EX;
    ptr = 0; blk = 0; nblk = 0;
    ph = P_IDLE; merr = 1'b0;
  endfunction

  function automatic void offer(output bit v,
                                output int t);
    int j;
    v = 1'b0; t = 0;
    if (ph == P_RUN)
      for (int k = 0; k < 16; k++) begin
        j = (ptr + k) % 16;
        if (!v && th[j] == RDY) begin
          v = 1'b1; t = j;
        end
      end
  endfunction

  task automatic compare();
    bit v; int t;
    offer(v, t);
    chk("issue_valid", sif.issue_valid, v);
    chk("issue_thread", sif.issue_thread, v ? t : 0);
    chk("busy", busy, ph != P_IDLE);
    chk("done", done, ph == P_DONE);
    chk("err", err, merr);
    chk("block_idx", block_idx, blk);
  endtask

  task automatic mstep(input bit st, input int nb,
                       input bit rdy, input bit rv,
                       input int rt, input int rk,
                       input bit mv, input int mt);
    int o [16];
    bit v, allex;
    int t;
    offer(v, t);
    o = th;
    allex = 1'b1;
    foreach (o[i]) if (o[i] != EX) allex = 1'b0;
    if (v && rdy) begin
      th[t] = INF;
      ptr = (t + 1) % 16;
    end
    if (rv) begin
      if (o[rt] == INF && rk != 3)
        th[rt] = (rk == 0) ? RDY : (rk == 1) ? MW : EX;
      else
        merr = 1'b1;
    end
    if (mv) begin
      if (o[mt] == MW) th[mt] = RDY;
      else merr = 1'b1;
    end
    case (ph)
      P_IDLE: if (st) begin
        nblk = nb; merr = 1'b0; blk = 0;
        if (nb == 0) ph = P_DONE;
        else begin
          foreach (th[i]) th[i] = RDY;
          ptr = 0; ph = P_RUN;
        end
      end
      P_RUN: if (allex) ph = P_NEXT;
      P_NEXT: if (blk == nblk - 1) ph = P_DONE;
        else begin
          blk++;
          foreach (th[i]) th[i] = RDY;
          ptr = 0; ph = P_RUN;
        end
      default: ph = P_IDLE;
    endcase
  endtask

  // Called at a falling edge; returns at the next one.
  task automatic cyc(input bit st, input int nb,
                     input bit rdy, input bit rv,
                     input int rt, input int rk,
                     input bit mv, input int mt);
    compare();
    last_fire   = sif.issue_valid && rdy;
    last_thread = int'(sif.issue_thread);
    start                = st;
    num_blocks           = DATA_W'(nb);
    sif.issue_ready      = rdy;
    sif.retire_valid     = rv;
    sif.retire_thread    = TID_W'(rt);
    sif.retire_kind      = 2'(rk);
    sif.mem_resp_valid   = mv;
    sif.mem_resp_thread  = TID_W'(mt);
    mstep(st, nb, rdy, rv, rt, rk, mv, mt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, rdy, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cyc(input bit inj);
    int inf [$];
    int mw [$];
    bit rv, mv, rdy, st;
    int rt, rk, mt, nb, r;
    foreach (th[i]) begin
      if (th[i] == INF) inf.push_back(i);
      if (th[i] == MW) mw.push_back(i);
    end
    rdy = $urandom_range(0, 9) < 7;
    rv = 0; rt = 0; rk = 0; mv = 0; mt = 0;
    if (inf.size() > 0 && $urandom_range(0, 9) < 6) begin
      rv = 1;
      rt = inf[$urandom_range(0, inf.size() - 1)];
      r = $urandom_range(0, 9);
      rk = (r < 5) ? 0 : (r < 7) ? 1 : 2;
    end
    if (mw.size() > 0 && $urandom_range(0, 9) < 5) begin
      mv = 1;
      mt = mw[$urandom_range(0, mw.size() - 1)];
    end
    if (inj && $urandom_range(0, 99) < 5) begin
      rv = 1;
      rt = $urandom_range(0, 15);
      rk = $urandom_range(0, 3);
    end
    if (inj && $urandom_range(0, 99) < 5) begin
      mv = 1;
      mt = $urandom_range(0, 15);
    end
    st = inj && $urandom_range(0, 99) < 3;
    nb = $urandom_range(0, 5);
    cyc(st, nb, rdy, rv, rt, rk, mv, mt);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_issue_valid"}, sif.issue_valid, 0);
    chk({tag, "_issue_thread"}, sif.issue_thread, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_block_idx"}, block_idx, 0);
    start = 0;
    sif.issue_ready = 0;
    sif.retire_valid = 0;
    sif.mem_resp_valid = 0;
    mreset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int iss_at [64];
    int seq [$];
    int blks [$];
    int nd, nv, d_at, cnt5;
    bit fin;

    sif.issue_ready     = 1'b0;
    sif.retire_valid    = 1'b0;
    sif.retire_thread   = '0;
    sif.retire_kind     = '0;
    sif.mem_resp_valid  = 1'b0;
    sif.mem_resp_thread = '0;
    mreset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset("reset");

    // Single block, every issue exits two cycles later.
    foreach (iss_at[i]) iss_at[i] = -1;
    nd = 0;
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      bit rv;
      int rt;
      rv = c >= 2 && iss_at[c - 2] >= 0;
      rt = rv ? iss_at[c - 2] : 0;
      if (done) begin
        nd++;
        chk("launch_done_blk", block_idx, 0);
      end
      cyc(0, 0, 1, rv, rt, 2, 0, 0);
      if (last_fire) begin
        iss_at[c] = last_thread;
        seq.push_back(last_thread);
      end
    end
    chk("launch_count", seq.size(), 16);
    for (int i = 0; i < seq.size() && i < 16; i++)
      chk("launch_seq", seq[i], i);
    chk("launch_done_pulses", nd, 1);
    chk("launch_busy_after", busy, 0);

    // Round-robin from ptr 4 with only 3 and 9 ready.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (16) idle(1);
    for (int t = 0; t < 4; t++) cyc(0, 0, 0, 1, t, 0, 0, 0);
    repeat (4) idle(1);
    cyc(0, 0, 0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 0, 0, 0);
    chk("rr_valid", sif.issue_valid, 1);
    chk("rr_offer", sif.issue_thread, 9);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("bp_hold", sif.issue_thread, 9);
    end
    idle(1);
    chk("rr_after", sif.issue_thread, 3);
    do_reset("rst_mid_run");

    // Memory wait hides a thread until its response.
    cnt5 = 0;
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (6) idle(1);
    cyc(0, 0, 0, 1, 5, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (last_fire && last_thread == 5) cnt5++;
    end
    chk("memwait_never_offered", cnt5, 0);
    chk("memwait_idle_offer", sif.issue_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5);
    chk("memresp_valid", sif.issue_valid, 1);
    chk("memresp_offer", sif.issue_thread, 5);
    cyc(0, 0, 0, 1, 5, 2, 0, 0);
    chk("exit_ready_err", err, 1);
    chk("exit_ready_keep", sif.issue_thread, 5);
    cyc(1, 7, 0, 0, 0, 0, 0, 0);
    chk("start_busy_err", err, 1);
    chk("start_busy_busy", busy, 1);
    chk("start_busy_blk", block_idx, 0);
    do_reset("rst2");

    // Zero blocks completes without any offer.
    nd = 0; nv = 0; d_at = -1;
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      if (done) begin
        nd++;
        if (d_at < 0) d_at = c;
      end
      if (sif.issue_valid) nv++;
      idle(1);
    end
    chk("zero_done_pulses", nd, 1);
    chk("zero_no_issue", nv, 0);
    chk("zero_done_soon", d_at >= 1 && d_at <= 2, 1);

    // Three blocks under random traffic.
    nd = 0; fin = 0;
    blks.push_back(0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000 && !fin; n++) begin
      if (int'(block_idx) != blks[$])
        blks.push_back(int'(block_idx));
      if (done) begin
        nd++;
        chk("multi_done_blk", block_idx, 2);
      end
      rnd_cyc(0);
      if (ph == P_IDLE) fin = 1;
    end
    if (!fin) chk("multi_timeout", 0, 1);
    chk("multi_blk_steps", blks.size(), 3);
    for (int i = 0; i < blks.size() && i < 3; i++)
      chk("multi_blk_seq", blks[i], i);
    chk("multi_done_pulses", nd, 1);
    chk("multi_err", err, 0);

    // Random kernels with injected protocol errors.
    for (int k = 0; k < 6; k++) begin
      fin = 0;
      cyc(1, $urandom_range(1, 4), 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 4000 && !fin; n++) begin
        rnd_cyc(1);
        if (ph == P_IDLE) fin = 1;
      end
      if (!fin) chk("rand_timeout", 0, 1);
      idle(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
